// File: rtl/ex_mem_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe_if
// Description : EX->MEM pipeline bus: EX results in, MEM-stage copies,
//               architectural flags, halt status and forwarding source out.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mem_pipe_if;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [1:0]  M_in;
    logic        WB_in;
    logic [3:0]  rd_in;
    logic        hlt_in;
    logic        fl_we;
    logic [2:0]  flags_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic [15:0] PC_in;
    logic [15:0] ALU_in;

    logic        valid;
    logic [1:0]  M;
    logic        WB;
    logic [3:0]  rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] PC;
    logic [15:0] ALU;
    logic [2:0]  flags;
    logic        halted;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [15:0] fwd_data;

    modport master (
        output stall, flush, valid_in, M_in, WB_in, rd_in, hlt_in, fl_we,
               flags_in, addr_in, wdata_in, PC_in, ALU_in,
        input  valid, M, WB, rd, addr, wdata, PC, ALU, flags, halted,
               fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  stall, flush, valid_in, M_in, WB_in, rd_in, hlt_in, fl_we,
               flags_in, addr_in, wdata_in, PC_in, ALU_in,
        output valid, M, WB, rd, addr, wdata, PC, ALU, flags, halted,
               fwd_valid, fwd_rd, fwd_data
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe
// Description : EX/MEM pipeline register with flags, RUN/HALT FSM and an
//               optional EX-to-EX forwarding source (macro EX_MEM_FWD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe (
    input  logic         clk,
    input  logic         rst,
    ex_mem_pipe_if.slave pipe
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      state_q;
    logic        halted_q;
    logic        valid_q;
    logic [1:0]  m_q;
    logic        wb_q;
    logic [3:0]  rd_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] pc_q;
    logic [15:0] alu_q;
    logic [2:0]  flags_q;

    logic        w_hlt;
    logic        w_flag_upd;

    assign w_hlt      = pipe.valid_in & pipe.hlt_in;
    assign w_flag_upd = pipe.valid_in & pipe.fl_we;

    // Priority per edge: reset, then HALT, then flush, then stall, then load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
            valid_q  <= 1'b0;
            m_q      <= 2'b00;
            wb_q     <= 1'b0;
            rd_q     <= 4'h0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            pc_q     <= 16'h0000;
            alu_q    <= 16'h0000;
            flags_q  <= 3'b000;
        end else if (state_q == S_HALT) begin
            valid_q <= 1'b0;
        end else if (pipe.flush) begin
            valid_q <= 1'b0;
            m_q     <= 2'b00;
            wb_q    <= 1'b0;
        end else if (!pipe.stall) begin
            valid_q <= pipe.valid_in;
            // HLT must reach MEM as a side-effect-free slot.
            m_q     <= w_hlt ? 2'b00 : pipe.M_in;
            wb_q    <= w_hlt ? 1'b0  : pipe.WB_in;
            rd_q    <= pipe.rd_in;
            addr_q  <= pipe.addr_in;
            wdata_q <= pipe.wdata_in;
            pc_q    <= pipe.PC_in;
            alu_q   <= pipe.ALU_in;
            if (w_flag_upd) begin
                flags_q <= pipe.flags_in;
            end
            if (w_hlt) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
            end
        end
    end

    assign pipe.valid  = valid_q;
    assign pipe.M      = valid_q ? m_q : 2'b00;
    assign pipe.WB     = valid_q & wb_q;
    assign pipe.rd     = rd_q;
    assign pipe.addr   = addr_q;
    assign pipe.wdata  = wdata_q;
    assign pipe.PC     = pc_q;
    assign pipe.ALU    = alu_q;
    assign pipe.flags  = flags_q;
    assign pipe.halted = halted_q;

`ifdef EX_MEM_FWD_EN
    // Loads (MemRead) have no ALU result worth forwarding.
    assign pipe.fwd_valid = valid_q & wb_q & ~m_q[0];
    assign pipe.fwd_rd    = rd_q;
    assign pipe.fwd_data  = alu_q;
`else
    assign pipe.fwd_valid = 1'b0;
    assign pipe.fwd_rd    = 4'h0;
    assign pipe.fwd_data  = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port stall  input  1  hold all state this cycle.
REQ-004 SHALL have port flush  input  1  insert bubble this cycle.
REQ-005 SHALL have port valid_in  input  1  EX holds a real instruction.
REQ-006 SHALL have port M_in  input  2  bit0 MemRead, bit1 MemWrite.
REQ-007 SHALL have port WB_in  input  1  register write enable.
REQ-008 SHALL have port rd_in  input  4  destination register.
REQ-009 SHALL have port hlt_in  input  1  instruction is HLT.
REQ-010 SHALL have port fl_we  input  1  instruction updates flags.
REQ-011 SHALL have port flags_in  input  3  {zr,neg,ov} from ALU.
REQ-012 SHALL have ports addr_in, wdata_in, PC_in, ALU_in  input  16 each  EX results.
REQ-013 SHALL have port valid  output  1  MEM-stage instruction is real.
REQ-014 SHALL have ports M (2), WB (1), rd (4), addr, wdata, PC, ALU (16 each)  output  registered copies feeding MEM.
REQ-015 SHALL have port flags  output  3  architectural {zr,neg,ov}.
REQ-016 SHALL have port halted  output  1  HLT has committed to MEM.
REQ-017 SHALL have ports fwd_valid (1), fwd_rd (4), fwd_data (16)  output  EX-to-EX forwarding source.

Function
REQ-018 SHALL apply per-edge priority: reset > halted > flush > stall > load.
REQ-019 Load (no higher-priority event) SHALL capture all *_in fields and set valid=valid_in; latency exactly one cycle.
REQ-020 Stall SHALL hold every register, including flags and FSM state, unchanged.
REQ-021 Flush SHALL clear valid and the M and WB registers; data fields, flags and FSM state hold.
REQ-022 Flush and stall together SHALL act as flush.
REQ-023 Outputs M and WB SHALL be gated by valid (M=0, WB=0 whenever valid=0).
REQ-024 Flags register SHALL update to flags_in only on a load edge with valid_in=1 and fl_we=1; otherwise hold.
REQ-025 FSM SHALL have states RUN and HALT; RUN->HALT on a load edge with valid_in=1 and hlt_in=1.
REQ-026 HLT instruction SHALL occupy MEM for exactly one cycle with valid=1, M=0, WB=0.
REQ-027 In HALT, the edge after entry SHALL clear valid, and all inputs including flush and stall SHALL be ignored; only reset exits.
REQ-028 halted SHALL equal 1 exactly while FSM is HALT.
REQ-029 fwd_valid SHALL equal valid & WB & ~M[0]; fwd_rd=rd; fwd_data=ALU (loads never forwarded).

Reset
REQ-030 On rst=0 at an edge: valid=0, M=0, WB=0, rd=0, addr=wdata=PC=ALU=0, flags=3'b000, FSM=RUN, halted=0.
REQ-031 Reset SHALL override stall, flush and HALT in the same cycle.

Configuration
REQ-032 Macro EX_MEM_FWD_EN defined: forwarding outputs behave per REQ-029.
REQ-033 Macro EX_MEM_FWD_EN undefined: fwd_valid, fwd_rd, fwd_data SHALL be constant 0; all other behaviour identical.

Verification
REQ-034 Load: valid_in=1, M_in=01, WB_in=1, rd_in=5, ALU_in=16'h1234 -> next cycle valid=1, M=01, WB=1, rd=5, ALU=16'h1234, fwd_valid=0 (load).
REQ-035 Stall+flush: after a loaded ADD (WB=1), assert stall 2 cycles then stall+flush -> outputs hold 2 cycles, then valid=0, M=0, WB=0, ALU unchanged.
REQ-036 Flags: fl_we=1, flags_in=3'b100 loaded; then fl_we=0, flags_in=3'b011 -> flags stays 3'b100; same with valid_in=0 -> stays 3'b100.
REQ-037 Halt: load HLT -> one cycle valid=1, halted=1; following cycles valid=0 despite valid_in=1, flush=1; rst=0 -> halted=0.
REQ-038 Forwarding: ALU op WB_in=1, rd_in=3, ALU_in=16'h00FF with EX_MEM_FWD_EN defined -> fwd_valid=1, fwd_rd=3, fwd_data=16'h00FF; macro undefined -> all 0.
REQ-039 Reset mid-stall with valid=1, flags=3'b111 -> next cycle all outputs per REQ-030.
